// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: edge-detects timer interrupt lines, latches them as
// pending events, presents the lowest-index unmasked pending source to the CPU,
// and keeps saturating per-source event counters.
module timer_irq_ctrl #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               ack_valid,
   input  logic [ID_W-1:0]    ack_id,
   input  logic               cnt_clr,
   input  logic [ID_W-1:0]    cnt_sel,
   output logic               irq_out,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] overflow,
   output logic               ack_err,
   output logic [7:0]         cnt_out
);

   typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

   localparam logic [ID_W:0] NumSrcW = (ID_W+1)'(NUM_SRC);

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] irq_q;
   logic [NUM_SRC-1:0] evt;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] overflow_q, overflow_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;
   logic               ack_ok;
   logic               ack_err_q, ack_err_d;
   logic [7:0]         cnt_q [NUM_SRC];
   logic [7:0]         cnt_d [NUM_SRC];

   assign evt    = irq_in & ~irq_q;
   assign ack_ok = (state_q == StAssert) && ack_valid && (ack_id == irq_id_q);

   // Event latching; a new event on the source being acknowledged wins over the clear.
   always_comb begin
      ack_clr = '0;
      if (ack_ok) begin
         ack_clr[irq_id_q] = 1'b1;
      end
      pending_d  = (pending_q & ~ack_clr) | evt;
      overflow_d = overflow_q | (evt & pending_q & ~ack_clr);
      ack_err_d  = ack_valid & ~ack_ok;
   end

   // Request FSM next state; IDLE picks the lowest unmasked pending source.
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      unique case (state_q)
         StIdle: begin
            for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
               if (pending_q[i] && irq_mask[i]) begin
                  irq_id_d = ID_W'(i);
                  state_d  = StAssert;
               end
            end
         end
         StAssert: begin
            if (ack_ok) begin
               state_d = StGap;
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Saturating event counters; a clear with a coincident event restarts at one.
   always_comb begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr) begin
            cnt_d[i] = evt[i] ? 8'd1 : 8'd0;
         end else if (evt[i] && (cnt_q[i] != 8'hFF)) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   // State registers; irq_q resets high so a level held through reset is not an event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         irq_q      <= '1;
         pending_q  <= '0;
         overflow_q <= '0;
         irq_id_q   <= '0;
         ack_err_q  <= 1'b0;
         cnt_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         irq_q      <= irq_in;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         irq_id_q   <= irq_id_d;
         ack_err_q  <= ack_err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Outputs; irq_out decodes the state so reset drops it without a clock.
   always_comb begin
      irq_out  = (state_q == StAssert);
      irq_id   = irq_id_q;
      pending  = pending_q;
      overflow = overflow_q;
      ack_err  = ack_err_q;
      cnt_out  = 8'd0;
      if ({1'b0, cnt_sel} < NumSrcW) begin
         cnt_out = cnt_q[cnt_sel];
      end
   end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: a cycle-level behavioural model checked against the DUT on
// every falling clock edge, plus directed scenarios with hand-computed expectations.
module tb_timer_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] irq_in = '0;
   logic [3:0] irq_mask = 4'b1111;
   logic       ack_valid = 1'b0;
   logic [1:0] ack_id = '0;
   logic       cnt_clr = 1'b0;
   logic [1:0] cnt_sel = '0;
   logic       irq_out;
   logic [1:0] irq_id;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic       ack_err;
   logic [7:0] cnt_out;

   int n_checks = 0;
   int n_errors = 0;

   timer_irq_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .irq_in   (irq_in),
      .irq_mask (irq_mask),
      .ack_valid(ack_valid),
      .ack_id   (ack_id),
      .cnt_clr  (cnt_clr),
      .cnt_sel  (cnt_sel),
      .irq_out  (irq_out),
      .irq_id   (irq_id),
      .pending  (pending),
      .overflow (overflow),
      .ack_err  (ack_err),
      .cnt_out  (cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: the source being served, a one-cycle gap flag, and plain counts.
   bit [3:0] m_prev, m_pend, m_ovf, m_evt;
   bit       m_serving, m_gap, m_err, m_hit, m_found;
   int       m_id;
   int       m_cnt [4];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_prev    = 4'b1111;
         m_pend    = '0;
         m_ovf     = '0;
         m_serving = 1'b0;
         m_gap     = 1'b0;
         m_err     = 1'b0;
         m_id      = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         m_evt = irq_in & ~m_prev;
         m_hit = m_serving && ack_valid && (int'(ack_id) == m_id);
         m_err = ack_valid && !m_hit;
         // Service decision uses the pending set as it was before this edge.
         if (m_serving) begin
            if (m_hit) begin
               m_serving = 1'b0;
               m_gap     = 1'b1;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else begin
            m_found = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (!m_found && m_pend[i] && irq_mask[i]) begin
                  m_found   = 1'b1;
                  m_id      = i;
                  m_serving = 1'b1;
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (m_hit && i == m_id) begin
               m_pend[i] = m_evt[i];
            end else begin
               if (m_evt[i] && m_pend[i]) m_ovf[i] = 1'b1;
               if (m_evt[i]) m_pend[i] = 1'b1;
            end
            if (cnt_clr) m_cnt[i] = m_evt[i] ? 1 : 0;
            else if (m_evt[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
         end
         m_prev = irq_in;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      check("cyc_irq_out", 32'(irq_out), 32'(m_serving));
      check("cyc_irq_id", 32'(irq_id), 32'(m_id));
      check("cyc_pending", 32'(pending), 32'(m_pend));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_ack_err", 32'(ack_err), 32'(m_err));
      check("cyc_cnt_out", 32'(cnt_out), 32'(m_cnt[cnt_sel]));
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic ack(input logic [1:0] id);
      ack_valid = 1'b1;
      ack_id    = id;
      cyc();
      ack_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      cyc(2);
      check("rst_irq_out", 32'(irq_out), 32'd0);
      check("rst_irq_id", 32'(irq_id), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_cnt", 32'(cnt_out), 32'd0);
      reset_n = 1'b1;
      cyc();

      // Single pulse on source 2, held three cycles
      irq_in = 4'b0100;
      cyc();
      check("pulse_pending", 32'(pending), 32'h4);
      check("pulse_irq_early", 32'(irq_out), 32'd0);
      cyc();
      check("pulse_irq_out", 32'(irq_out), 32'd1);
      check("pulse_irq_id", 32'(irq_id), 32'd2);
      cyc();
      irq_in  = 4'b0000;
      cnt_sel = 2'd2;
      #1;
      check("pulse_cnt2", 32'(cnt_out), 32'd1);
      ack(2'd2);
      check("pulse_gap_out", 32'(irq_out), 32'd0);
      check("pulse_cleared", 32'(pending), 32'd0);
      cyc(2);

      // Priority: sources 3 and 1 together
      irq_in = 4'b1010;
      cyc();
      irq_in = 4'b0000;
      check("prio_pending", 32'(pending), 32'ha);
      cyc();
      check("prio_id1", 32'(irq_id), 32'd1);
      ack(2'd1);
      check("prio_gap", 32'(irq_out), 32'd0);
      check("prio_left", 32'(pending), 32'h8);
      cyc();
      check("prio_idle", 32'(irq_out), 32'd0);
      cyc();
      check("prio_out3", 32'(irq_out), 32'd1);
      check("prio_id3", 32'(irq_id), 32'd3);
      ack(2'd3);
      cyc(2);

      // Masking
      irq_mask = 4'b0000;
      irq_in   = 4'b0001;
      cyc();
      irq_in = 4'b0000;
      check("mask_pending", 32'(pending), 32'h1);
      cyc(2);
      check("mask_no_irq", 32'(irq_out), 32'd0);
      irq_mask = 4'b0001;
      cyc();
      check("mask_irq_out", 32'(irq_out), 32'd1);
      check("mask_irq_id", 32'(irq_id), 32'd0);
      ack(2'd0);
      irq_mask = 4'b1111;
      cyc(2);

      // Overflow, bad acknowledge, event coincident with valid acknowledge
      irq_in = 4'b0010;
      cyc();
      irq_in = 4'b0000;
      cyc();
      irq_in = 4'b0010;
      cyc();
      irq_in = 4'b0000;
      check("ovf_set", 32'(overflow), 32'h2);
      ack(2'd0);
      check("err_pulse", 32'(ack_err), 32'd1);
      check("err_irq_held", 32'(irq_out), 32'd1);
      check("err_id_held", 32'(irq_id), 32'd1);
      cyc();
      check("err_one_cycle", 32'(ack_err), 32'd0);
      irq_in    = 4'b0010;
      ack_valid = 1'b1;
      ack_id    = 2'd1;
      cyc();
      irq_in = 4'b0000;
      check("coinc_pending", 32'(pending), 32'h2);
      check("coinc_ovf", 32'(overflow), 32'h2);
      check("coinc_gap", 32'(irq_out), 32'd0);
      cyc();
      ack_valid = 1'b0;
      check("gap_ack_err", 32'(ack_err), 32'd1);
      cyc();
      check("coinc_rearm", 32'(irq_out), 32'd1);
      ack(2'd1);
      cyc(2);

      // Counter saturation and clear with coincident event
      irq_mask = 4'b0000;
      cnt_sel  = 2'd0;
      for (int n = 0; n < 300; n++) begin
         irq_in = 4'b0001;
         cyc();
         irq_in = 4'b0000;
         cyc();
      end
      check("cnt_sat", 32'(cnt_out), 32'd255);
      irq_in  = 4'b0001;
      cnt_clr = 1'b1;
      cyc();
      irq_in  = 4'b0000;
      cnt_clr = 1'b0;
      #1;
      check("cnt_clr_evt", 32'(cnt_out), 32'd1);
      cnt_sel = 2'd3;
      #1;
      check("cnt_clr_other", 32'(cnt_out), 32'd0);
      cyc();

      // Level held through reset release, then asynchronous reset mid-request
      irq_in  = 4'b0001;
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      check("rst_level_pend", 32'(pending), 32'd0);
      check("rst_level_irq", 32'(irq_out), 32'd0);
      irq_in   = 4'b0000;
      irq_mask = 4'b1111;
      cyc();
      irq_in = 4'b0100;
      cyc();
      irq_in = 4'b0000;
      cyc();
      check("pre_rst_irq", 32'(irq_out), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_rst_irq", 32'(irq_out), 32'd0);
      check("async_rst_pend", 32'(pending), 32'd0);
      cyc();
      reset_n = 1'b1;
      cyc(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
